pdm_mic_ctrl: RTL and testbench
===============================

# pdm_mic_ctrl

Controller for the PDM microphone front end of the PCM audio path. It generates the gated microphone bit clock from the system clock. It sequences the microphone through idle, wake-up and run phases. During run it decimates the 1-bit PDM stream into unsigned PCM words by counting ones over a fixed window, with one valid pulse per word for the downstream PCM/audio stages.

## Interface
Parameters:
- CLK_DIV, 16: half-period of mic_clk in clk cycles (≥2); mic_clk period = 2·CLK_DIV clk cycles.
- DECIM, 64: mic_clk periods per PCM word (power of two, ≥2).
- WAKE_CYCLES, 1024: mic_clk periods discarded after start before accumulation begins (≥1).
- PCM_W, $clog2(DECIM)+1: pcm_data width; holds 0..DECIM inclusive.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- start  in  1  level/pulse; sampled only in IDLE.
- stop  in  1  pulse; honoured in WAKE and RUN.
- mic_data  in  1  PDM bit from microphone.
- mic_clk  out  1  microphone bit clock; low when not running.
- pcm_data  out  PCM_W  ones-count of the last completed window.
- pcm_valid  out  1  one-cycle strobe, new pcm_data.
- busy  out  1  high in WAKE or RUN.
- led  out  1  high in RUN only.

## Operation
- States: IDLE, WAKE, RUN.
- IDLE:
  - mic_clk held 0, half-period counter at 0, accumulators cleared.
  - start=1 → WAKE next cycle.
- Clock generation, active in WAKE and RUN:
  - hcnt counts 0..CLK_DIV-1.
  - At CLK_DIV-1, mic_clk toggles and hcnt returns to 0.
  - The first toggle after entering WAKE is 0→1, CLK_DIV cycles after entry.
- Sample point ("fall tick"): the cycle in which mic_clk is toggled 1→0. mic_data is sampled in that cycle.
- WAKE:
  - Counts fall ticks.
  - On the WAKE_CYCLES-th fall tick → RUN; that tick's bit is discarded.
- RUN:
  - Each fall tick adds mic_data to ones and increments bitcnt.
  - On the DECIM-th tick of a window, pcm_data ← ones + mic_data.
  - pcm_valid pulses for one cycle, and ones and bitcnt restart at 0.
  - Windows are back-to-back with no gap.
- stop in WAKE/RUN:
  - → IDLE next cycle; mic_clk driven 0 that same next cycle.
  - Partial window discarded with no pcm_valid.
  - pcm_data holds its last value.
- start and stop both high in IDLE → remain IDLE (stop wins).
- A fall tick coinciding with stop is ignored, including a window-completing tick.
- Arithmetic: ones is PCM_W bits unsigned, so no overflow at DECIM. bitcnt is $clog2(DECIM) bits and wraps naturally.

## Timing
- Reset values:
  - state=IDLE, mic_clk=0, pcm_data=0, pcm_valid=0, busy=0, led=0.
  - All counters 0.
  - Reset mid-operation behaves identically: mic_clk low next cycle, no pcm_valid.
- All outputs are registered.
- busy rises the cycle after start is accepted. It falls the cycle after stop.
- led rises the cycle after the last WAKE fall tick.
- pcm_valid and pcm_data update in the cycle after the window-completing fall tick.
- First pcm_valid after start: (WAKE_CYCLES+DECIM)·2·CLK_DIV + 1 cycles after the start-accept cycle.
- Steady state: one pcm_valid every DECIM·2·CLK_DIV cycles.

## Structure
- Package pdm_pkg holds:
  - The state enum (IDLE/WAKE/RUN).
  - Constant/function for PCM_W.
  - Default parameter constants shared with the downstream PCM stages.
- One sub-module, pdm_clk_gen: half-period counter with enable, driving mic_clk and a fall_tick strobe.
  - Disabled → counter 0, mic_clk 0.
- The FSM and the decimation accumulator live in pdm_mic_ctrl.

## Test plan
Benches use CLK_DIV=2, DECIM=8, WAKE_CYCLES=4.

- Reset/idle:
  - Hold reset 3 cycles, then idle 50 cycles.
  - → all outputs 0; mic_clk never toggles.
- Startup latency:
  - Pulse start, mic_data=1 constant.
  - → mic_clk period 4 cycles.
  - → busy the next cycle.
  - → led after 4 fall ticks.
  - → first pcm_valid 49 cycles after start accept, pcm_data=8.
- Pattern decimation:
  - mic_data alternating 1,0 per fall tick → pcm_data=4 each window.
  - All-zero → pcm_data=0.
  - pcm_valid spacing exactly 32 cycles.
- Stop mid-window:
  - stop after 5 bits of a window.
  - → IDLE and mic_clk=0 next cycle.
  - → no pcm_valid; pcm_data keeps previous value.
  - → restart behaves as in the startup-latency scenario.
- Simultaneous events:
  - start+stop together in IDLE → stays IDLE.
  - stop on a window-completing fall tick → no pcm_valid.
- Reset mid-RUN:
  - Assert reset during RUN.
  - → next cycle all outputs at reset values; no spurious pcm_valid.

Source files
------------

// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM microphone front end: controller states,
// PCM word width helper and default timing constants used by the PCM stages.
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAKE = 2'd1,
    RUN  = 2'd2
  } pdm_state_t;

  localparam int DEF_CLK_DIV     = 16;
  localparam int DEF_DECIM       = 64;
  localparam int DEF_WAKE_CYCLES = 1024;

  // A full window of ones equals DECIM, so one extra bit beyond log2.
  function automatic int pcm_width(input int decim);
    return $clog2(decim) + 1;
  endfunction

  localparam int DEF_PCM_W = pcm_width(DEF_DECIM);

endpackage

// File: rtl/pdm_clk_gen.sv
// Gated microphone bit clock: divides clk by 2*CLK_DIV while enabled and
// flags the cycle in which mic_clk is about to fall (the PDM sample point).
module pdm_clk_gen #(
  parameter int CLK_DIV = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic mic_clk,
  output logic fall_tick
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [HW-1:0] HLAST = HW'(CLK_DIV - 1);

  logic [HW-1:0] hcnt;
  logic          wrap;

  assign wrap      = en && (hcnt == HLAST);
  assign fall_tick = wrap && mic_clk;

  // Dropping enable parks the divider so the next start begins with a 0->1 edge.
  always_ff @(posedge clk) begin
    if (reset || !en) begin
      hcnt    <= '0;
      mic_clk <= 1'b0;
    end else if (wrap) begin
      hcnt    <= '0;
      mic_clk <= ~mic_clk;
    end else begin
      hcnt    <= hcnt + 1'b1;
    end
  end

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM microphone controller: sequences IDLE/WAKE/RUN, gates the mic clock and
// decimates the PDM stream into ones-count PCM words with a valid strobe.
module pdm_mic_ctrl
  import pdm_pkg::*;
#(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int DECIM       = DEF_DECIM,
  parameter int WAKE_CYCLES = DEF_WAKE_CYCLES,
  parameter int PCM_W       = pcm_width(DECIM)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             mic_data,
  output logic             mic_clk,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_valid,
  output logic             busy,
  output logic             led
);

  localparam int BW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [BW-1:0] BLAST = BW'(DECIM - 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam logic [WW-1:0] WLAST = WW'(WAKE_CYCLES - 1);

  pdm_state_t state, state_next;
  logic       busy_d, led_d;
  logic       clk_en, fall_tick;

  logic [WW-1:0]    wake_cnt;
  logic [BW-1:0]    bitcnt;
  logic [PCM_W-1:0] ones;
  logic [PCM_W-1:0] bit_ext;

  // Gating on stop as well guarantees mic_clk is low the cycle IDLE is entered.
  assign clk_en  = (state != IDLE) && !stop;
  assign bit_ext = {{(PCM_W-1){1'b0}}, mic_data};

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .en        (clk_en),
    .mic_clk   (mic_clk),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      led   <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= busy_d;
      led   <= led_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && !stop) state_next = WAKE;
      WAKE: begin
        if (stop)
          state_next = IDLE;
        else if (fall_tick && (wake_cnt == WLAST))
          state_next = RUN;
      end
      RUN:  if (stop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status flags follow the next state so they line up with the state register.
  always_comb begin
    busy_d = (state_next != IDLE);
    led_d  = (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset || (state != WAKE) || stop)
      wake_cnt <= '0;
    else if (fall_tick)
      wake_cnt <= wake_cnt + 1'b1;
  end

  // Ticks coinciding with stop are dropped, even one that would close a window.
  always_ff @(posedge clk) begin
    pcm_valid <= 1'b0;
    if (reset) begin
      ones     <= '0;
      bitcnt   <= '0;
      pcm_data <= '0;
    end else if ((state != RUN) || stop) begin
      ones     <= '0;
      bitcnt   <= '0;
    end else if (fall_tick) begin
      if (bitcnt == BLAST) begin
        pcm_data  <= ones + bit_ext;
        pcm_valid <= 1'b1;
        ones      <= '0;
        bitcnt    <= '0;
      end else begin
        ones      <= ones + bit_ext;
        bitcnt    <= bitcnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Scoreboard bench for pdm_mic_ctrl with CLK_DIV=2, DECIM=8, WAKE_CYCLES=4:
// expected PCM words and their arrival cycles are queued, a monitor checks them.
module tb_pdm_mic_ctrl;

  localparam int CLK_DIV     = 2;
  localparam int DECIM       = 8;
  localparam int WAKE_CYCLES = 4;
  localparam int PCM_W       = 4;

  logic             clk = 1'b0;
  logic             reset, start, stop, mic_data;
  logic             mic_clk, pcm_valid, busy, led;
  logic [PCM_W-1:0] pcm_data;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int mode = 0;
  int accept_cyc = 0;
  int t0, t1, t2;

  typedef struct {
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  pdm_mic_ctrl #(
    .CLK_DIV     (CLK_DIV),
    .DECIM       (DECIM),
    .WAKE_CYCLES (WAKE_CYCLES),
    .PCM_W       (PCM_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .mic_data  (mic_data),
    .mic_clk   (mic_clk),
    .pcm_data  (pcm_data),
    .pcm_valid (pcm_valid),
    .busy      (busy),
    .led       (led)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Pattern source: 0 = all zero, 1 = all one, 2 = alternating every 4 cycles,
  // i.e. alternating per fall tick since ticks are exactly 4 cycles apart.
  initial begin
    mic_data = 1'b0;
    forever begin
      @(negedge clk);
      case (mode)
        0:       mic_data = 1'b0;
        1:       mic_data = 1'b1;
        default: mic_data = cyc[2];
      endcase
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkState(input string name, input logic mc, input logic b,
                            input logic l, input logic v, input int d);
    checkOutput({name, ".mic_clk"}, {31'd0, mic_clk}, {31'd0, mc});
    checkOutput({name, ".busy"}, {31'd0, busy}, {31'd0, b});
    checkOutput({name, ".led"}, {31'd0, led}, {31'd0, l});
    checkOutput({name, ".pcm_valid"}, {31'd0, pcm_valid}, {31'd0, v});
    checkOutput({name, ".pcm_data"}, {28'd0, pcm_data}, d);
  endtask

  task automatic applyStimulus(input logic s, input logic p, input logic r);
    accept_cyc = cyc;
    start = s;
    stop  = p;
    reset = r;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    reset = 1'b0;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (pcm_valid === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL spurious_pcm_valid: got pcm_valid=1 data=%0d expected no word (cycle %0d)",
                 pcm_data, cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("pcm_data", {28'd0, pcm_data}, e.data);
        checkOutput("pcm_valid_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 50; i++) begin
      checkState("idle", 1'b0, 1'b0, 1'b0, 1'b0, 0);
      @(negedge clk);
    end

    // Startup latency and pattern decimation
    applyStimulus(1'b1, 1'b0, 1'b0);
    t0 = accept_cyc;
    sb.push_back('{8, t0 + 49});
    sb.push_back('{8, t0 + 81});
    checkOutput("busy_rise", {31'd0, busy}, 1);
    for (int i = 1; i <= 8; i++) begin
      waitUntil(t0 + i);
      checkOutput("mic_clk_period", {31'd0, mic_clk}, (((i - 1) % 4) >= 2) ? 1 : 0);
    end
    waitUntil(t0 + 16);
    checkOutput("led_before_run", {31'd0, led}, 0);
    waitUntil(t0 + 17);
    checkOutput("led_rise", {31'd0, led}, 1);

    waitUntil(t0 + 81);
    mode = 2;
    sb.push_back('{4, t0 + 113});
    sb.push_back('{4, t0 + 145});
    waitUntil(t0 + 145);
    mode = 0;
    sb.push_back('{0, t0 + 177});
    waitUntil(t0 + 177);
    mode = 1;
    sb.push_back('{8, t0 + 209});

    // Stop after 5 bits of the next window
    waitUntil(t0 + 230);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("stop_mid", 1'b0, 1'b0, 1'b0, 1'b0, 8);
    waitUntil(t0 + 271);
    checkState("stop_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8);

    // Restart, then stop exactly on a window-completing tick
    mode = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t1 = accept_cyc;
    sb.push_back('{8, t1 + 49});
    checkOutput("restart_busy", {31'd0, busy}, 1);
    waitUntil(t1 + 17);
    checkOutput("restart_led", {31'd0, led}, 1);
    waitUntil(t1 + 49);
    mode = 0;
    waitUntil(t1 + 80);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkState("stop_on_tick", 1'b0, 1'b0, 1'b0, 1'b0, 8);
    waitUntil(t1 + 120);
    checkState("stop_on_tick_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8);

    // start and stop together in IDLE
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkState("start_stop", 1'b0, 1'b0, 1'b0, 1'b0, 8);
    repeat (10) @(negedge clk);
    checkState("start_stop_hold", 1'b0, 1'b0, 1'b0, 1'b0, 8);

    // Reset in the middle of RUN
    mode = 2;
    applyStimulus(1'b1, 1'b0, 1'b0);
    t2 = accept_cyc;
    sb.push_back('{4, t2 + 49});
    waitUntil(t2 + 60);
    checkOutput("run_led", {31'd0, led}, 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkState("reset_run", 1'b0, 1'b0, 1'b0, 1'b0, 0);
    waitUntil(t2 + 160);
    checkState("after_reset", 1'b0, 1'b0, 1'b0, 1'b0, 0);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missing_pcm_valid: got no word expected data %0d at cycle %0d", e.data, e.cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
